// File: rtl/dmem_responder_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wmask;
  logic [3:0]        req_rmask;
  logic              req_sext;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_wr;

  modport master (
    output req_valid, req_addr, req_wmask, req_rmask, req_sext, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_wr
  );

  modport slave (
    input  req_valid, req_addr, req_wmask, req_rmask, req_sext, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_wr
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory: one request in flight, response 1+WAIT_STATES cycles after accept.
// Response is held until resp_ready; req_ready is high only when idle and out of reset.
module dmem_responder #(
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;

  logic [7:0]       mem [DEPTH];
  logic [IDX_W-1:0] idx [4];
  logic             accept;
  logic [31:0]      raw;
  logic [31:0]      rd_asm;
  logic             sign;

  function automatic logic [IDX_W-1:0] lane_idx(input logic [ADDR_W-1:0] a, input int k);
    int s;
    s = (int'(a) + k) % DEPTH;
    return s[IDX_W-1:0];
  endfunction

  // Mask bit i addresses byte addr+(3-i): bit3 is the lowest address (big-endian lanes).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i] = lane_idx(bus.req_addr, 3 - i);
    end
  end

  assign bus.req_ready = reset && (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    raw    = '0;
    rd_asm = '0;
    sign   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_rmask[i]) raw[8*i +: 8] = mem[idx[i]];
    end
    sign = bus.req_rmask[1] ? raw[15] : raw[7];
    for (int i = 0; i < 4; i++) begin
      rd_asm[8*i +: 8] = (!bus.req_rmask[i] && bus.req_sext) ? {8{sign}} : raw[8*i +: 8];
    end
  end

  // Read data is taken from pre-write contents because the array updates at this same edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_wmask[i]) mem[idx[i]] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d = rd_asm;
          wr_d    = |bus.req_wmask;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_wr    = wr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with three wait states.
module tb_dmem_responder;
  localparam int WS = 3;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(7)) bus ();

  dmem_responder #(.ADDR_W(7), .DEPTH(128), .WAIT_STATES(WS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic xact(input logic [6:0] a, input logic [3:0] wm, input logic [3:0] rm,
                      input logic s, input logic [31:0] wd,
                      output logic [31:0] rd, output logic wr, output int lat);
    int n;
    @(negedge clk);
    bus.req_addr  = a;
    bus.req_wmask = wm;
    bus.req_rmask = rm;
    bus.req_sext  = s;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata;
    wr = bus.resp_wr;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b exp ready=0 valid=0", bus.req_ready, bus.resp_valid);
    end
    checks++;
    if (bus.resp_rdata !== 32'd0 || bus.resp_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got rdata=%h wr=%b exp rdata=0 wr=0", bus.resp_rdata, bus.resp_wr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h10, 4'b1111, 4'b0000, 1'b0, 32'hDEADBEEF, rd, wr, lat);
    checks++;
    if (rd !== 32'd0 || wr !== 1'b1) begin
      errors++;
      $display("FAIL word_write got rdata=%h wr=%b exp rdata=00000000 wr=1", rd, wr);
    end
    xact(7'h10, 4'b0000, 4'b1111, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || wr !== 1'b0) begin
      errors++;
      $display("FAIL word_read got rdata=%h wr=%b exp rdata=deadbeef wr=0", rd, wr);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h10, 4'b0000, 4'b1111, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (lat !== 1 + WS) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", lat, 1 + WS);
    end
  endtask

  task automatic test_sext();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h10, 4'b0000, 4'b0001, 1'b1, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'hFFFFFFEF) begin
      errors++;
      $display("FAIL sext_byte got %h exp ffffffef", rd);
    end
    xact(7'h10, 4'b0000, 4'b0001, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'h000000EF) begin
      errors++;
      $display("FAIL zext_byte got %h exp 000000ef", rd);
    end
    xact(7'h10, 4'b0000, 4'b0011, 1'b1, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'hFFFFBEEF) begin
      errors++;
      $display("FAIL sext_half got %h exp ffffbeef", rd);
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h10, 4'b0100, 4'b1111, 1'b0, 32'h00AA0000, rd, wr, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || wr !== 1'b1) begin
      errors++;
      $display("FAIL partial_old got rdata=%h wr=%b exp rdata=deadbeef wr=1", rd, wr);
    end
    xact(7'h10, 4'b0000, 4'b1111, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'hDEAABEEF) begin
      errors++;
      $display("FAIL partial_new got %h exp deaabeef", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h7E, 4'b1111, 4'b0000, 1'b0, 32'h11223344, rd, wr, lat);
    xact(7'h7E, 4'b0000, 4'b0001, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'h00000044) begin
      errors++;
      $display("FAIL wrap_byte got %h exp 00000044", rd);
    end
    xact(7'h00, 4'b0000, 4'b1100, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'h33440000) begin
      errors++;
      $display("FAIL wrap_low got %h exp 33440000", rd);
    end
  endtask

  task automatic test_empty();
    logic [31:0] rd; logic wr; int lat;
    xact(7'h10, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFFFF, rd, wr, lat);
    checks++;
    if (rd !== 32'd0 || wr !== 1'b0) begin
      errors++;
      $display("FAIL empty got rdata=%h wr=%b exp rdata=00000000 wr=0", rd, wr);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.req_addr  = 7'h10;
    bus.req_wmask = 4'b0000;
    bus.req_rmask = 4'b1111;
    bus.req_sext  = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 7'h7E;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.resp_rdata !== 32'hDEAABEEF) begin
      errors++;
      $display("FAIL bp_first_data got %h exp deaabeef", bus.resp_rdata);
    end
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEAABEEF || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=deaabeef ready=0",
                 c, bus.resp_valid, bus.resp_rdata, bus.req_ready);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", bus.resp_valid, bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got ready=%b exp 0", bus.req_ready);
    end
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL bp_second_data got valid=%b rdata=%h exp valid=1 rdata=11223344", bus.resp_valid, bus.resp_rdata);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic wr; int lat;
    @(negedge clk);
    bus.req_addr  = 7'h20;
    bus.req_wmask = 4'b1111;
    bus.req_rmask = 4'b0000;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got valid=%b ready=%b exp valid=0 ready=0", bus.resp_valid, bus.req_ready);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_wr !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle got ready=%b valid=%b wr=%b exp ready=1 valid=0 wr=0",
               bus.req_ready, bus.resp_valid, bus.resp_wr);
    end
    xact(7'h20, 4'b0000, 4'b1111, 1'b0, 32'h0, rd, wr, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL midreset_kept got %h exp cafef00d", rd);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_rmask  = '0;
    bus.req_sext   = 1'b0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_word();
    test_latency();
    test_sext();
    test_partial();
    test_wrap();
    test_empty();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
